// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: control-flow op encodings, FSM state encoding, sequential PC step.
package pc_seq_pkg;

  // Decoded control-flow op presented by decode; codes 6-7 behave as OP_NONE.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BR   = 3'd1,
    OP_BRC  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5
  } br_op_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BUBBLE,
    ST_HALTED
  } state_e;

  // Byte distance between consecutive instructions.
  localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack (LIFO) holding DEPTH entries of W bits.
// Latency: dout shows the top of stack combinationally; push/pop take effect on the next edge.
// Backpressure: none; a push when full silently overwrites the oldest entry.
//
// Ports: clk, rst (sync, active-high), push, pop, din (W), dout (W, top entry),
//        empty, full. push and pop are never asserted together by the sequencer;
//        if they were, push wins.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;   // slot the next push writes
  logic [AW-1:0] top_idx;  // slot holding the newest entry
  logic [AW:0]   cnt;

  // Pointer arithmetic wraps mod DEPTH, so a push when full lands on the
  // oldest entry while the count saturates at DEPTH.
  assign top_idx = wr_ptr - AW'(1);
  assign dout    = mem[top_idx];
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (!full) cnt <= cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_idx;
      cnt    <= cnt - (AW+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, takes one decoded control-flow op per handshake.
// Latency: pc reflects an accepted op one cycle after the accept edge; redirects add one bubble cycle.
// Backpressure: instr_ready drops during reset, for the bubble after a redirect, and forever once halted.
//
// Ports: clk, rst (sync, active-high); instr_valid/instr_ready handshake with decode;
//        br_op (3), br_cond, br_offset (OFF_W, signed word offset); pc (PC_W) and
//        pc_valid to fetch; halted; sticky RAS error flags ras_ovf / ras_unf.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              OFF_W     = 21,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       br_op,
  input  logic             br_cond,
  input  logic [OFF_W-1:0] br_offset,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             halted,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int SW = OFF_W + 2;

  state_e            state, state_nx;
  logic [PC_W-1:0]   pc_nx;
  logic              accept;
  logic signed [SW-1:0] off_scaled;
  logic [PC_W-1:0]   tgt, seq;
  logic              ras_push, ras_pop, ras_empty, ras_full;
  logic [PC_W-1:0]   ras_top;
  logic              set_ovf, set_unf;

  // Word offset -> byte offset by appending two zeros; the signed size cast
  // sign-extends to PC_W and the add wraps modulo 2^PC_W.
  assign off_scaled = {br_offset, 2'b00};
  assign tgt        = pc + PC_W'(off_scaled);
  assign seq        = pc + PC_W'(PC_INCR);

  // rst gates ready so an op presented during the reset cycle is never accepted.
  assign instr_ready = (state == ST_RUN) && !rst;
  assign pc_valid    = (state == ST_RUN);
  assign halted      = (state == ST_HALTED);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          case (br_op)
            OP_BR: begin
              pc_nx    = tgt;
              state_nx = ST_BUBBLE;
            end
            OP_BRC: begin
              if (br_cond) begin
                pc_nx    = tgt;
                state_nx = ST_BUBBLE;
              end else begin
                pc_nx = seq;
              end
            end
            OP_CALL: begin
              ras_push = 1'b1;
              set_ovf  = ras_full;
              pc_nx    = tgt;
              state_nx = ST_BUBBLE;
            end
            OP_RET: begin
              if (ras_empty) begin
                // Nothing to return to: flag it and fall through sequentially.
                set_unf = 1'b1;
                pc_nx   = seq;
              end else begin
                ras_pop  = 1'b1;
                pc_nx    = ras_top;
                state_nx = ST_BUBBLE;
              end
            end
            OP_HALT: begin
              state_nx = ST_HALTED;
            end
            default: begin
              pc_nx = seq;
            end
          endcase
        end
      end
      ST_BUBBLE: state_nx = ST_RUN;
      ST_HALTED: state_nx = ST_HALTED;
      default:   state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      ras_ovf <= ras_ovf | set_ovf;
      ras_unf <= ras_unf | set_unf;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (seq),
    .dout  (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  br_op = 3'd0;
  logic        br_cond = 1'b0;
  logic [20:0] br_offset = '0;
  logic [31:0] pc;
  logic        pc_valid, halted, ras_ovf, ras_unf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W(32), .OFF_W(21), .RAS_DEPTH(4), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_op(br_op), .br_cond(br_cond), .br_offset(br_offset), .pc(pc),
    .pc_valid(pc_valid), .halted(halted), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  // Present one op for a single cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic c, input logic [20:0] off);
    instr_valid = 1'b1; br_op = op; br_cond = c; br_offset = off;
    @(posedge clk); #1;
    instr_valid = 1'b0; br_op = 3'd0; br_cond = 1'b0; br_offset = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Move from a known pc to a target with a BR, then ride out the bubble.
  task automatic goto(input logic [31:0] from, input logic [31:0] to);
    logic [31:0] d;
    d = to - from;
    issue(3'd1, 1'b0, d[22:2]);
    tick();
  endtask

  // Reset with a taken branch in flight; it must be overridden.
  task automatic test_reset(input string tag);
    rst = 1'b1; instr_valid = 1'b1; br_op = 3'd1; br_offset = 21'h10;
    @(posedge clk); #1;
    n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL %s ready_in_rst got=%b exp=0", tag, instr_ready); end
    rst = 1'b0; instr_valid = 1'b0; br_op = 3'd0; br_offset = '0;
    #1;
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL %s rst_pc got=%h exp=00000100", tag, pc); end
    n_cmp++; if ({instr_ready, pc_valid, halted, ras_ovf, ras_unf} !== 5'b11000) begin
      n_bad++; $display("FAIL %s rst_flags got=%b exp=11000", tag, {instr_ready, pc_valid, halted, ras_ovf, ras_unf});
    end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; br_op = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (pc !== 32'h100 + 32'(4 * i) || instr_ready !== 1'b1) begin
        n_bad++; $display("FAIL seq%0d pc=%h ready=%b exp pc=%h ready=1", i, pc, instr_ready, 32'h100 + 32'(4 * i));
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_branch();
    goto(32'h10C, 32'h200);
    n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL goto200 got=%h exp=00000200", pc); end
    issue(3'd1, 1'b0, 21'h1FFFFE);
    n_cmp++; if (pc !== 32'h1F8) begin n_bad++; $display("FAIL br_neg got=%h exp=000001f8", pc); end
    n_cmp++; if (instr_ready !== 1'b0 || pc_valid !== 1'b0) begin
      n_bad++; $display("FAIL bubble ready=%b pc_valid=%b exp 0/0", instr_ready, pc_valid);
    end
    tick();
    n_cmp++; if (instr_ready !== 1'b1 || pc_valid !== 1'b1) begin
      n_bad++; $display("FAIL after_bubble ready=%b pc_valid=%b exp 1/1", instr_ready, pc_valid);
    end
    goto(32'h1F8, 32'h200);
    issue(3'd2, 1'b0, 21'h10);
    n_cmp++; if (pc !== 32'h204 || instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL brc_nt pc=%h ready=%b exp 00000204/1", pc, instr_ready);
    end
    issue(3'd2, 1'b1, 21'h4);
    n_cmp++; if (pc !== 32'h214 || instr_ready !== 1'b0) begin
      n_bad++; $display("FAIL brc_t pc=%h ready=%b exp 00000214/0", pc, instr_ready);
    end
    tick();
    issue(3'd7, 1'b1, 21'h40);
    n_cmp++; if (pc !== 32'h218 || instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL op7 pc=%h ready=%b exp 00000218/1", pc, instr_ready);
    end
  endtask

  task automatic test_call_ret();
    goto(32'h218, 32'h10);
    issue(3'd3, 1'b0, 21'h40);
    n_cmp++; if (pc !== 32'h110) begin n_bad++; $display("FAIL call pc got=%h exp=00000110", pc); end
    tick();
    issue(3'd4, 1'b0, 21'h0);
    n_cmp++; if (pc !== 32'h14 || ras_unf !== 1'b0) begin
      n_bad++; $display("FAIL ret pc=%h unf=%b exp 00000014/0", pc, ras_unf);
    end
    tick();
    issue(3'd4, 1'b0, 21'h0);
    n_cmp++; if (pc !== 32'h18 || ras_unf !== 1'b1 || instr_ready !== 1'b1) begin
      n_bad++; $display("FAIL ret_empty pc=%h unf=%b ready=%b exp 00000018/1/1", pc, ras_unf, instr_ready);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h204; exp_ret[1] = 32'h1C4; exp_ret[2] = 32'h184; exp_ret[3] = 32'h144;
    test_reset("rst4");
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ras_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early call%0d got=%b exp=0", i, ras_ovf); end
      issue(3'd3, 1'b0, 21'h10);
      tick();
    end
    n_cmp++; if (ras_ovf !== 1'b1 || pc !== 32'h240) begin
      n_bad++; $display("FAIL ovf pc=%h ovf=%b exp 00000240/1", pc, ras_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      issue(3'd4, 1'b0, 21'h0);
      n_cmp++; if (pc !== exp_ret[i] || ras_unf !== 1'b0) begin
        n_bad++; $display("FAIL lifo%0d pc=%h unf=%b exp %h/0", i, pc, ras_unf, exp_ret[i]);
      end
      tick();
    end
    issue(3'd4, 1'b0, 21'h0);
    n_cmp++; if (ras_unf !== 1'b1 || pc !== 32'h148) begin
      n_bad++; $display("FAIL ret5 pc=%h unf=%b exp 00000148/1", pc, ras_unf);
    end
  endtask

  task automatic test_wrap();
    goto(32'h148, 32'hFFFFFFFC);
    n_cmp++; if (pc !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL goto_top got=%h exp=fffffffc", pc); end
    issue(3'd0, 1'b0, 21'h0);
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL seq_wrap got=%h exp=00000000", pc); end
    issue(3'd1, 1'b0, 21'h0FFFFF);
    n_cmp++; if (pc !== 32'h003FFFFC) begin n_bad++; $display("FAIL off_max got=%h exp=003ffffc", pc); end
    tick();
    goto(32'h003FFFFC, 32'h0);
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL goto0 got=%h exp=00000000", pc); end
    issue(3'd1, 1'b0, 21'h100000);
    n_cmp++; if (pc !== 32'hFFC00000) begin n_bad++; $display("FAIL off_min got=%h exp=ffc00000", pc); end
    tick();
  endtask

  task automatic test_halt();
    test_reset("rst6a");
    issue(3'd4, 1'b0, 21'h0);
    issue(3'd5, 1'b0, 21'h0);
    n_cmp++; if ({halted, instr_ready, pc_valid} !== 3'b100 || pc !== 32'h104) begin
      n_bad++; $display("FAIL halt hrv=%b pc=%h exp 100/00000104", {halted, instr_ready, pc_valid}, pc);
    end
    instr_valid = 1'b1; br_op = 3'd1; br_offset = 21'h8;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (pc !== 32'h104 || halted !== 1'b1 || instr_ready !== 1'b0) begin
        n_bad++; $display("FAIL frozen%0d pc=%h halted=%b ready=%b exp 00000104/1/0", i, pc, halted, instr_ready);
      end
    end
    instr_valid = 1'b0;
    test_reset("rst_halted");
    issue(3'd3, 1'b0, 21'h4);
    n_cmp++; if (pc_valid !== 1'b0 || pc !== 32'h110) begin
      n_bad++; $display("FAIL call_bubble pc=%h pc_valid=%b exp 00000110/0", pc, pc_valid);
    end
    test_reset("rst_bubble");
    // The pushed return address must not survive reset.
    issue(3'd4, 1'b0, 21'h0);
    n_cmp++; if (ras_unf !== 1'b1 || pc !== 32'h104) begin
      n_bad++; $display("FAIL ras_cleared pc=%h unf=%b exp 00000104/1", pc, ras_unf);
    end
  endtask

  initial begin
    test_reset("rst1");
    test_back_to_back();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
